// File: rtl/ahb_pkg.sv
// Shared AHB3-Lite encodings and the copy-engine state type.
package ahb_pkg;

  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_BUSY   = 2'b01;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
  localparam logic [1:0] HTRANS_SEQ    = 2'b11;

  localparam logic [2:0] HSIZE_WORD    = 3'b010;
  localparam logic [2:0] HBURST_SINGLE = 3'b000;
  localparam logic [3:0] HPROT_DATA    = 4'b0011;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_RA,
    ST_RD_WA,
    ST_WD_RA
  } copy_state_t;

endpackage

// File: rtl/ahb_copy_master.sv
// AHB3-Lite block-copy initiator: overlaps read and write data phases,
// forwarding each word's checksum untouched.
module ahb_copy_master
  import ahb_pkg::*;
#(
  parameter int unsigned AW    = 32,
  parameter int unsigned LEN_W = 16
) (
  input  logic             s_clk_i,
  input  logic             s_reset_i,
  input  logic             cmd_valid_i,
  output logic             cmd_ready_o,
  input  logic [AW-1:0]    src_i,
  input  logic [AW-1:0]    dst_i,
  input  logic [LEN_W-1:0] len_i,
  output logic             busy_o,
  output logic             done_o,
  output logic             err_o,
  output logic [LEN_W-1:0] count_o,
  output logic [AW-1:0]    m_haddr_o,
  output logic [1:0]       m_htrans_o,
  output logic             m_hwrite_o,
  output logic [2:0]       m_hsize_o,
  output logic [2:0]       m_hburst_o,
  output logic [3:0]       m_hprot_o,
  output logic             m_hmastlock_o,
  output logic [31:0]      m_hwdata_o,
  output logic [6:0]       m_hwchecksum_o,
  input  logic [31:0]      m_hrdata_i,
  input  logic [6:0]       m_hrchecksum_i,
  input  logic             m_hready_i,
  input  logic             m_hresp_i
);

  copy_state_t      r_state, w_state_nxt;
  logic [AW-1:0]    r_src, r_dst;
  logic [LEN_W-1:0] r_len, r_cnt;
  logic [31:0]      r_wdata;
  logic [6:0]       r_wchk;
  logic             r_done, r_err;

  logic             w_accept, w_src_adv, w_dst_adv, w_capture, w_cnt_inc;
  logic             w_done_nxt, w_err_nxt, w_remain;
  logic [1:0]       w_htrans;
  logic [AW-1:0]    w_haddr;
  logic             w_hwrite;

  // r_cnt equals the index of the word in its write data phase
  assign w_remain = (r_cnt != r_len - LEN_W'(1));

  always_comb begin
    w_state_nxt = r_state;
    w_accept    = 1'b0;
    w_src_adv   = 1'b0;
    w_dst_adv   = 1'b0;
    w_capture   = 1'b0;
    w_cnt_inc   = 1'b0;
    w_done_nxt  = 1'b0;
    w_err_nxt   = 1'b0;
    w_htrans    = HTRANS_IDLE;
    w_haddr     = '0;
    w_hwrite    = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (cmd_valid_i) begin
          w_accept = 1'b1;
          if (len_i == '0) w_done_nxt = 1'b1;
          else             w_state_nxt = ST_RA;
        end
      end
      ST_RA: begin
        w_htrans = HTRANS_NONSEQ;
        w_haddr  = r_src;
        if (m_hready_i) begin
          w_src_adv   = 1'b1;
          w_state_nxt = ST_RD_WA;
        end
      end
      ST_RD_WA: begin
        w_htrans = m_hresp_i ? HTRANS_IDLE : HTRANS_NONSEQ;
        w_haddr  = r_dst;
        w_hwrite = 1'b1;
        if (m_hready_i) begin
          if (m_hresp_i) begin
            w_done_nxt  = 1'b1;
            w_err_nxt   = 1'b1;
            w_state_nxt = ST_IDLE;
          end else begin
            w_capture   = 1'b1;
            w_dst_adv   = 1'b1;
            w_state_nxt = ST_WD_RA;
          end
        end
      end
      ST_WD_RA: begin
        w_htrans = (w_remain && !m_hresp_i) ? HTRANS_NONSEQ : HTRANS_IDLE;
        w_haddr  = r_src;
        if (m_hready_i) begin
          if (m_hresp_i) begin
            w_done_nxt  = 1'b1;
            w_err_nxt   = 1'b1;
            w_state_nxt = ST_IDLE;
          end else begin
            w_cnt_inc = 1'b1;
            if (w_remain) begin
              w_src_adv   = 1'b1;
              w_state_nxt = ST_RD_WA;
            end else begin
              w_done_nxt  = 1'b1;
              w_state_nxt = ST_IDLE;
            end
          end
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge s_clk_i) begin
    if (s_reset_i) r_state <= ST_IDLE;
    else           r_state <= w_state_nxt;
  end

  always_ff @(posedge s_clk_i) begin
    if (s_reset_i) begin
      r_src   <= '0;
      r_dst   <= '0;
      r_len   <= '0;
      r_cnt   <= '0;
      r_wdata <= '0;
      r_wchk  <= '0;
      r_done  <= 1'b0;
      r_err   <= 1'b0;
    end else begin
      r_done <= w_done_nxt;
      r_err  <= w_err_nxt;
      if (w_accept) begin
        r_src <= src_i & ~AW'(3);
        r_dst <= dst_i & ~AW'(3);
        r_len <= len_i;
        r_cnt <= '0;
      end
      if (w_src_adv) r_src <= r_src + AW'(4);
      if (w_dst_adv) r_dst <= r_dst + AW'(4);
      if (w_capture) begin
        r_wdata <= m_hrdata_i;
        r_wchk  <= m_hrchecksum_i;
      end
      if (w_cnt_inc) r_cnt <= r_cnt + LEN_W'(1);
    end
  end

  assign cmd_ready_o    = (r_state == ST_IDLE);
  assign busy_o         = (r_state != ST_IDLE);
  assign done_o         = r_done;
  assign err_o          = r_err;
  assign count_o        = r_cnt;
  assign m_haddr_o      = w_haddr;
  assign m_htrans_o     = w_htrans;
  assign m_hwrite_o     = w_hwrite;
  assign m_hsize_o      = HSIZE_WORD;
  assign m_hburst_o     = HBURST_SINGLE;
  assign m_hprot_o      = HPROT_DATA;
  assign m_hmastlock_o  = 1'b0;
  assign m_hwdata_o     = r_wdata;
  assign m_hwchecksum_o = r_wchk;

endmodule

// File: tb/tb_ahb_copy_master.sv
// Bench for ahb_copy_master: AHB RAM subordinate model with wait/error injection
// and a scoreboard of expected destination writes.
module tb_ahb_copy_master;
  import ahb_pkg::*;

  localparam int unsigned AW    = 32;
  localparam int unsigned LEN_W = 16;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             cmd_valid, cmd_ready;
  logic [AW-1:0]    src, dst;
  logic [LEN_W-1:0] len;
  logic             busy, done, err;
  logic [LEN_W-1:0] count;
  logic [AW-1:0]    m_haddr;
  logic [1:0]       m_htrans;
  logic             m_hwrite, m_hmastlock;
  logic [2:0]       m_hsize, m_hburst;
  logic [3:0]       m_hprot;
  logic [31:0]      m_hwdata;
  logic [6:0]       m_hwchk;
  logic [31:0]      s_hrdata;
  logic [6:0]       s_hrchk;
  logic             s_hready, s_hresp;

  always #5 clk = ~clk;

  ahb_copy_master #(.AW(AW), .LEN_W(LEN_W)) dut (
    .s_clk_i(clk), .s_reset_i(rst),
    .cmd_valid_i(cmd_valid), .cmd_ready_o(cmd_ready),
    .src_i(src), .dst_i(dst), .len_i(len),
    .busy_o(busy), .done_o(done), .err_o(err), .count_o(count),
    .m_haddr_o(m_haddr), .m_htrans_o(m_htrans), .m_hwrite_o(m_hwrite),
    .m_hsize_o(m_hsize), .m_hburst_o(m_hburst), .m_hprot_o(m_hprot),
    .m_hmastlock_o(m_hmastlock), .m_hwdata_o(m_hwdata), .m_hwchecksum_o(m_hwchk),
    .m_hrdata_i(s_hrdata), .m_hrchecksum_i(s_hrchk),
    .m_hready_i(s_hready), .m_hresp_i(s_hresp)
  );

  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] data;
    logic [6:0]  chk;
  } wr_t;

  wr_t         sb_q[$];
  logic [38:0] mem [logic [31:0]];
  int          checks   = 0;
  int          failures = 0;

  int unsigned wait_mode = 0;
  logic        err_en    = 1'b0;
  logic [31:0] err_addr  = '0;
  int unsigned active_cycles = 0;
  int unsigned err_cycles    = 0;

  task automatic check(input string tag, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h expected=0x%0h", tag, act, exp);
    end
  endtask

  function automatic logic [38:0] pat(input logic [31:0] a);
    return {a[8:2] ^ 7'h2B, (a * 32'd2654435761) ^ 32'hC3C3_0F0F};
  endfunction

  function automatic logic [38:0] rd_mem(input logic [31:0] a);
    return mem.exists(a) ? mem[a] : 39'h0;
  endfunction

  // DUT outputs are sampled mid-cycle; the subordinate acts on these at the edge
  logic [AW-1:0] n_haddr;
  logic [1:0]    n_htrans;
  logic          n_hwrite;
  logic [31:0]   n_hwdata;
  logic [6:0]    n_hwchk;

  always @(negedge clk) begin
    n_haddr  = m_haddr;
    n_htrans = m_htrans;
    n_hwrite = m_hwrite;
    n_hwdata = m_hwdata;
    n_hwchk  = m_hwchk;
    if (m_htrans != HTRANS_IDLE) active_cycles++;
    if (!rst && s_hresp && !s_hready) begin
      err_cycles++;
      check("err_cancel_htrans", m_htrans, HTRANS_IDLE);
    end
  end

  logic        act, dp_write;
  logic [31:0] dp_addr;
  int unsigned wl, es;
  logic [73:0] snap;
  logic        snap_v;

  always @(posedge clk) begin : subordinate
    logic [73:0] cur;
    wr_t         e;
    cur = {n_haddr, n_htrans, n_hwrite, n_hwdata, n_hwchk};
    if (rst) begin
      act = 1'b0; dp_write = 1'b0; dp_addr = '0; wl = 0; es = 0; snap_v = 1'b0;
      s_hready <= 1'b1; s_hresp <= 1'b0; s_hrdata <= '0; s_hrchk <= '0;
    end else begin
      if (snap_v && !s_hresp) check("wait_stable", cur, snap);
      snap_v = !s_hready && !s_hresp;
      snap   = cur;
      if (s_hready) begin
        if (act && dp_write && !s_hresp) begin
          mem[dp_addr] = {n_hwchk, n_hwdata};
          check("wr_expected", sb_q.size() != 0, 1);
          if (sb_q.size() != 0) begin
            e = sb_q.pop_front();
            check("waddr", dp_addr, e.addr);
            check("wdata", n_hwdata, e.data);
            check("wchk", n_hwchk, e.chk);
          end
        end
        act      = n_htrans[1];
        dp_addr  = n_haddr;
        dp_write = n_hwrite;
        wl = !act ? 0 : (wait_mode == 1) ? 2 : (wait_mode == 2) ? $urandom_range(3, 0) : 0;
        es = (act && err_en && !dp_write && dp_addr == err_addr) ? 1 : 0;
      end
      if (!act) begin
        s_hready <= 1'b1; s_hresp <= 1'b0;
      end else if (wl > 0) begin
        wl--;
        s_hready <= 1'b0; s_hresp <= 1'b0;
        s_hrdata <= 32'hDEAD_BEEF; s_hrchk <= 7'h7F;
      end else if (es == 1) begin
        es = 2;
        s_hready <= 1'b0; s_hresp <= 1'b1;
      end else if (es == 2) begin
        s_hready <= 1'b1; s_hresp <= 1'b1;
      end else begin
        s_hready <= 1'b1; s_hresp <= 1'b0;
        if (!dp_write) {s_hrchk, s_hrdata} <= rd_mem(dp_addr);
      end
    end
  end

  task automatic load_cmd(input logic [31:0] a_src, input logic [31:0] a_dst,
                          input int unsigned a_len, input int unsigned n_ok);
    logic [31:0] s, d;
    logic [38:0] p;
    s = a_src & ~32'h3;
    d = a_dst & ~32'h3;
    mem.delete();
    for (int unsigned i = 0; i < a_len; i++) mem[s + 32'(4 * i)] = pat(s + 32'(4 * i));
    for (int unsigned i = 0; i < n_ok; i++) begin
      p = pat(s + 32'(4 * i));
      sb_q.push_back('{addr: d + 32'(4 * i), data: p[31:0], chk: p[38:32]});
    end
    cmd_valid = 1'b1; src = a_src; dst = a_dst; len = LEN_W'(a_len);
  endtask

  task automatic run_cmd(input logic [31:0] a_src, input logic [31:0] a_dst,
                         input int unsigned a_len, input int unsigned n_ok,
                         input logic exp_err, input logic chk_time, input string tag);
    logic [31:0] s, d;
    int unsigned c;
    logic        seen;
    s = a_src & ~32'h3;
    d = a_dst & ~32'h3;
    @(negedge clk);
    check({tag, "_ready"}, cmd_ready, 1);
    load_cmd(a_src, a_dst, a_len, n_ok);
    @(negedge clk);
    cmd_valid = 1'b0;
    c = 1;
    seen = done;
    check({tag, "_busy"}, busy, a_len != 0);
    while (!seen && c < 400) begin
      @(negedge clk);
      c++;
      seen = done;
    end
    check({tag, "_done_seen"}, seen, 1);
    if (chk_time) check({tag, "_done_cycle"}, c, (a_len == 0) ? 1 : 2 * a_len + 2);
    check({tag, "_err"}, err, exp_err);
    check({tag, "_count"}, count, n_ok);
    check({tag, "_sb_empty"}, sb_q.size(), 0);
    for (int unsigned i = 0; i < n_ok; i++)
      check({tag, "_mem"}, rd_mem(d + 32'(4 * i)), pat(s + 32'(4 * i)));
    if (exp_err) check({tag, "_unwritten"}, mem.exists(d + 32'(4 * n_ok)), 0);
    @(negedge clk);
    check({tag, "_done_pulse"}, done, 0);
  endtask

  initial begin
    cmd_valid = 1'b0; src = '0; dst = '0; len = '0;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    check("rst_htrans", m_htrans, HTRANS_IDLE);
    check("rst_haddr", m_haddr, 0);
    check("rst_hwrite", m_hwrite, 0);
    check("rst_hwdata", m_hwdata, 0);
    check("rst_hwchk", m_hwchk, 0);
    check("rst_done", done, 0);
    check("rst_err", err, 0);
    check("rst_busy", busy, 0);
    check("rst_count", count, 0);
    check("rst_ready", cmd_ready, 1);
    check("hsize", m_hsize, 3'b010);
    check("hburst", m_hburst, 3'b000);
    check("hprot", m_hprot, 4'b0011);
    check("hmastlock", m_hmastlock, 0);
    rst = 1'b0;

    run_cmd(32'h100, 32'h800, 3, 3, 1'b0, 1'b1, "basic");

    active_cycles = 0;
    run_cmd(32'h200, 32'h900, 0, 0, 1'b0, 1'b1, "zero");
    check("zero_no_bus", active_cycles, 0);

    wait_mode = 1;
    run_cmd(32'h400, 32'hA00, 2, 2, 1'b0, 1'b0, "wait");
    wait_mode = 0;

    err_en = 1'b1; err_addr = 32'h504; err_cycles = 0;
    run_cmd(32'h500, 32'hB00, 3, 1, 1'b1, 1'b0, "rderr");
    check("rderr_cycles", err_cycles, 1);
    err_en = 1'b0;

    wait_mode = 2;
    run_cmd(32'h1000, 32'h1800, 16, 16, 1'b0, 1'b0, "contend");
    wait_mode = 0;

    run_cmd(32'hFFFF_FFF9, 32'h2000, 3, 3, 1'b0, 1'b1, "wrap");

    // reset during cycle 5 of an 8-word copy: only word 0 has been written
    @(negedge clk);
    load_cmd(32'h3000, 32'h3800, 8, 8);
    @(negedge clk);
    cmd_valid = 1'b0;
    repeat (4) @(negedge clk);
    check("rst_mid_pre_count", count, 1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("rst_mid_htrans", m_htrans, HTRANS_IDLE);
    check("rst_mid_count", count, 0);
    check("rst_mid_busy", busy, 0);
    check("rst_mid_sb_left", sb_q.size(), 7);
    sb_q.delete();
    run_cmd(32'h3000, 32'h3800, 8, 8, 1'b0, 1'b1, "post_rst");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/ahb_copy_master.md
# ahb_copy_master

AHB3-Lite initiator that copies a block of 32-bit words from a source to a destination region, forwarding each word's 7-bit checksum unchanged so EDAC-protected data stays protected. It sits on the master side of an AHB interconnect, typically on port 1 of the dual-port RAM controller, alongside the core on port 0. Read and write data phases are overlapped, giving 2 cycles per word at zero wait states.

## Interface
- AW, 32: byte address width of m_haddr_o, src_i and dst_i.
- LEN_W, 16: width of the word-count field.
- s_clk_i  in  1  clock, rising edge.
- s_reset_i  in  1  synchronous, active-high reset.
- cmd_valid_i  in  1  start request, sampled only when cmd_ready_o=1.
- cmd_ready_o  out  1  high in IDLE.
- src_i, dst_i  in  AW each  word-aligned start addresses; bits [1:0] are ignored and forced to 0.
- len_i  in  LEN_W  number of words to copy.
- busy_o  out  1  high outside IDLE.
- done_o  out  1  one-cycle pulse when the command ends.
- err_o  out  1  one-cycle pulse coincident with done_o when the command ended on an ERROR response.
- count_o  out  LEN_W  words fully written for the current or last command.
- m_haddr_o  out  AW  AHB address.
- m_htrans_o  out  2  AHB transfer type.
- m_hwrite_o  out  1  AHB write enable.
- m_hsize_o  out  3  constant 3'b010 (word).
- m_hburst_o  out  3  constant 3'b000 (SINGLE).
- m_hprot_o  out  4  constant 4'b0011.
- m_hmastlock_o  out  1  constant 0.
- m_hwdata_o  out  32  AHB write data.
- m_hwchecksum_o  out  7  checksum accompanying m_hwdata_o.
- m_hrdata_i  in  32  AHB read data.
- m_hrchecksum_i  in  7  checksum accompanying m_hrdata_i.
- m_hready_i  in  1  AHB ready.
- m_hresp_i  in  1  AHB response (1 = ERROR).

## Operation
- **States:** IDLE, RA, RD_WA, WD_RA.
- **IDLE**
  - m_htrans_o is IDLE (2'b00).
  - On cmd_valid_i: latch src, dst and len; clear count_o.
  - len=0: pulse done_o next cycle and stay in IDLE; no bus activity.
  - Otherwise go to RA.
- **RA:** drive NONSEQ read at src. When m_hready_i=1, go to RD_WA.
- **RD_WA:** read data phase for word n, plus NONSEQ write address at dst.
  - When m_hready_i=1 and m_hresp_i=0: capture m_hrdata_i and m_hrchecksum_i; go to WD_RA.
- **WD_RA:** write data phase for word n.
  - m_hwdata_o and m_hwchecksum_o come from the capture registers.
  - If words remain, also drive a NONSEQ read at src+4(n+1); otherwise drive IDLE.
  - When m_hready_i=1 and m_hresp_i=0: increment count_o.
  - Then go to RD_WA if words remain; otherwise return to IDLE and pulse done_o.
- **Address progression:** read and write addresses advance by 4 per word and wrap modulo 2^AW; no protection against wrap.
- **Error handling:**
  - First error cycle (m_hresp_i=1, m_hready_i=0): force m_htrans_o to IDLE, cancelling the overlapped address phase.
  - Second error cycle (m_hresp_i=1, m_hready_i=1): go to IDLE and pulse done_o with err_o.
  - count_o keeps the number of words completed before the error.
- **During wait states** (m_hready_i=0, m_hresp_i=0): every address-phase and data-phase output holds stable.
- cmd_valid_i outside IDLE is ignored.

## Timing
- **Reset values:**
  - State IDLE; m_htrans_o 0; m_haddr_o 0; m_hwrite_o 0; m_hwdata_o 0; m_hwchecksum_o 0.
  - done_o 0; err_o 0; busy_o 0; count_o 0; cmd_ready_o 1.
- **Zero-wait cycle schedule** (command accepted at edge 0):
  - Cycle 1: R0 address.
  - Cycle 2: R0 data + W0 address.
  - Cycle 3: W0 data + R1 address.
  - Pattern continues; done_o is high in cycle 2·len+2.
- A new command can be accepted in the cycle after done_o.
- Reset asserted mid-command: the next cycle is IDLE with htrans IDLE. Any in-flight transfer is abandoned, and the subordinate is reset on the same net.
- All outputs are registered or decoded from registered state. The only combinational input-to-output path is m_hresp_i → m_htrans_o, which cancels the address phase during the first error cycle.

## Structure
- Shared package ahb_pkg holds:
  - HTRANS_IDLE/BUSY/NONSEQ/SEQ.
  - HSIZE_WORD, HBURST_SINGLE.
  - The copy-state enum.
- No sub-module: one FSM, two address counters, a word counter and the data/checksum capture register.

## Test plan
- **Basic copy:** src=0x100, dst=0x800, len=3 on a zero-wait RAM → RAM[0x800..0x808] equals RAM[0x100..0x108] including checksums; done_o in cycle 8; count_o=3.
- **Zero length:** len=0 → done_o one cycle later; m_htrans_o stays 0 throughout.
- **Wait states:** RAM inserts 2 wait states on every data phase, len=2 → address and data outputs stable during waits; result correct; count_o=2.
- **Read error:** ERROR on word 1's read → overlapped write address cancelled (htrans IDLE in the first error cycle); dst+4 unwritten; done_o and err_o high; count_o=1.
- **Dual-port contention:** a second master hammers port 0 while the engine uses port 1 of the dual-port RAM controller, len=16 → all 16 words copied with correct checksums.
- **Reset mid-copy:** s_reset_i asserted in cycle 5 of len=8 → IDLE, htrans 0, count_o 0 next cycle; a new command then completes normally.
